imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of `sign_extension`: packs a 64-bit immediate into the immediate fields of a 32-bit RISC-V instruction word.
- Serves the boot/self-test instruction injector, which builds instruction streams before they are written to instruction memory.
- Checks range and alignment of each immediate.
- Expands a 32-bit load-immediate pseudo-op into a LUI + ADDIW pair.
- Valid/ready on both sides, registered output.

Parameters:
XLEN, 64, width of `imm_in`; range checks are relative to XLEN.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
imm_type  input  3  000 I, 001 S, 010 SB, 011 U, 100 UJ, 101 LI pseudo, 110/111 illegal
base_instr  input  32  opcode/rd/rs/funct fields; immediate bit positions are ignored and overwritten
imm_in  input  XLEN  signed immediate / byte offset / constant
out_valid  output  1  out_instr valid
out_ready  input  1  consumer accepts when out_valid && out_ready
out_instr  output  32  encoded instruction word
out_last  output  1  final word of the current request
out_err  output  1  immediate not representable; registered with its word

Behaviour:
- Reset (async, rst_n=0): state=EMPTY, out_valid=0, out_instr=0, out_last=0, out_err=0. in_ready=1 after release.
- Representable ranges:
  - I/S: imm_in is sign-extended from bit 11.
  - SB: sign-extended from bit 12, imm[0]=0.
  - U: sign-extended from bit 31, imm[11:0]=0.
  - UJ: sign-extended from bit 20, imm[0]=0.
  - LI: sign-extended from bit 31.
- Field placement (all other bits come from base_instr):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - SB: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - UJ: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- LI, using rd=base_instr[11:7]:
  - If imm fits signed 12 bits: one word, ADDI rd,x0,imm (opcode 0010011, funct3 000).
  - Otherwise two words:
    - hi=(imm+0x800)>>12 (20 bits), lo=imm[11:0].
    - Word 1: LUI rd,hi (opcode 0110111).
    - Word 2: ADDIW rd,rd,lo (opcode 0011011, funct3 000, rs1=rd).
- Error (range, alignment, or type 110/111):
  - Single word: base_instr with the type's immediate bits forced to 0.
  - out_err=1, out_last=1.
  - Illegal types pass base_instr unchanged.
- FSM states: EMPTY, WORD1, WORD2.
  - EMPTY: in_ready=1, out_valid=0. Accept → WORD1; encoded word registered, visible the cycle after accept (latency 1).
  - WORD1: out_valid=1, out_last=!need2.
    - out_ready && need2 → WORD2 (in_ready=0).
    - out_ready && !need2: in_ready=out_ready; a same-cycle accept reloads WORD1 back-to-back (no bubble), else → EMPTY.
    - !out_ready: hold all outputs stable; in_ready=0.
  - WORD2: out_valid=1, out_last=1, out_err=0, in_ready=out_ready. On out_ready, accept a new request → WORD1, else → EMPTY.
- in_ready is combinational from out_ready and state; no combinational path from in_valid to out_*.
- Mid-operation reset discards any pending second word.
- Throughput: 1 word/cycle sustained.

Test Plan:
1. I-type: base=0x00050513, imm=0xFFFF_FFFF_FFFF_FFFF, out_ready=1 → next cycle out_instr=0xFFF50513, out_err=0, out_last=1. Re-decoding via `sign_extension` type 000 gives imm back.
2. SB: base=0x00000063, imm=-4 → 0xFE000EE3. imm=3 → out_err=1, out_instr=0x00000063.
3. LI: base=0x00000500, imm=0x12345FFF → 0x12346537 (last=0), then 0xFFF5051B (last=1). Same with imm=0x7FF → single word 0x7FF00513, last=1.
4. Backpressure: LI request with out_ready=0 for 3 cycles → out_instr holds 0x12346537, in_ready=0. Releasing out_ready delivers both words in order; a new request is accepted only in the WORD2 handoff cycle.
5. Range error: I-type imm=2048, base=0x00050513 → out_instr=0x00050513, out_err=1. S-type imm=-2048, base=0x00A12023 → 0x80A12023, out_err=0.
6. Reset: assert rst_n=0 while in WORD1 of a two-word LI → out_valid=0 immediately. After release, in_ready=1 and the ADDIW word is never emitted.

Source files
------------

// File: rtl/imm_encoder.sv
// Packs a signed immediate into a RISC-V instruction word, with range checks.
// Expands the load-immediate pseudo-op into ADDI or a LUI + ADDIW pair.
module imm_encoder #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      imm_type,
    input  logic [31:0]     base_instr,
    input  logic [XLEN-1:0] imm_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            out_last,
    output logic            out_err
);

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;

    typedef enum logic [1:0] {
        EMPTY,
        WORD1,
        WORD2
    } state_t;

    state_t state, state_nx;

    logic        t_i, t_s, t_sb, t_u, t_uj, t_li;
    logic        fit12, fit13, fit21, fit32;
    logic        ok;
    logic [31:0] fimm;
    logic [4:0]  rd;
    logic [19:0] hi;
    logic [31:0] enc_w1, enc_w2;
    logic        enc_need2;
    logic [31:0] word2_q;
    logic        load_new, load_w2;

    assign t_i  = (imm_type == 3'b000);
    assign t_s  = (imm_type == 3'b001);
    assign t_sb = (imm_type == 3'b010);
    assign t_u  = (imm_type == 3'b011);
    assign t_uj = (imm_type == 3'b100);
    assign t_li = (imm_type == 3'b101);

    // A value fits when every bit above the sign bit copies it.
    assign fit12 = (&imm_in[XLEN-1:11]) | ~(|imm_in[XLEN-1:11]);
    assign fit13 = (&imm_in[XLEN-1:12]) | ~(|imm_in[XLEN-1:12]);
    assign fit21 = (&imm_in[XLEN-1:20]) | ~(|imm_in[XLEN-1:20]);
    assign fit32 = (&imm_in[XLEN-1:31]) | ~(|imm_in[XLEN-1:31]);

    always_comb begin
        ok = 1'b0;
        unique case (1'b1)
            t_i, t_s: ok = fit12;
            t_sb:     ok = fit13 && !imm_in[0];
            t_u:      ok = fit32 && (imm_in[11:0] == 12'd0);
            t_uj:     ok = fit21 && !imm_in[0];
            t_li:     ok = fit32;
            default:  ok = 1'b0;
        endcase
    end

    assign fimm = ok ? imm_in[31:0] : 32'd0;
    assign rd   = base_instr[11:7];
    // Round up so the sign-extended low part of ADDIW lands on the value.
    assign hi   = fimm[31:12] + {19'd0, fimm[11]};

    always_comb begin
        enc_w1    = base_instr;
        enc_w2    = 32'd0;
        enc_need2 = 1'b0;
        unique case (1'b1)
            t_i: enc_w1[31:20] = fimm[11:0];
            t_s: begin
                enc_w1[31:25] = fimm[11:5];
                enc_w1[11:7]  = fimm[4:0];
            end
            t_sb: begin
                enc_w1[31]    = fimm[12];
                enc_w1[30:25] = fimm[10:5];
                enc_w1[11:8]  = fimm[4:1];
                enc_w1[7]     = fimm[11];
            end
            t_u: enc_w1[31:12] = fimm[31:12];
            t_uj: begin
                enc_w1[31]    = fimm[20];
                enc_w1[30:21] = fimm[10:1];
                enc_w1[20]    = fimm[11];
                enc_w1[19:12] = fimm[19:12];
            end
            t_li: begin
                if (!ok) begin
                    enc_w1[31:20] = 12'd0;
                end else if (fit12) begin
                    enc_w1 = {fimm[11:0], 5'd0, 3'b000, rd, OP_IMM};
                end else begin
                    enc_w1    = {hi, rd, OP_LUI};
                    enc_w2    = {fimm[11:0], rd, 3'b000, rd, OP_IMM32};
                    enc_need2 = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // out_last low while in WORD1 marks a pending second word.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load_new  = 1'b0;
        load_w2   = 1'b0;
        unique case (state)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_new = 1'b1;
                    state_nx = WORD1;
                end
            end
            WORD1: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (!out_last) begin
                        load_w2  = 1'b1;
                        state_nx = WORD2;
                    end else begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            load_new = 1'b1;
                        end else begin
                            state_nx = EMPTY;
                        end
                    end
                end
            end
            WORD2: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load_new = 1'b1;
                        state_nx = WORD1;
                    end else begin
                        state_nx = EMPTY;
                    end
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_instr <= 32'd0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            word2_q   <= 32'd0;
        end else if (load_new) begin
            out_instr <= enc_w1;
            out_last  <= !enc_need2;
            out_err   <= !ok;
            word2_q   <= enc_w2;
        end else if (load_w2) begin
            out_instr <= word2_q;
            out_last  <= 1'b1;
            out_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed scenarios plus randomized traffic
// scored against an arithmetic model of the encoding rules.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_type;
    logic [31:0] base_instr;
    logic [63:0] imm_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        out_err;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] w;
        bit          last;
        bit          err;
    } exp_t;

    exp_t q[$];

    imm_encoder #(.XLEN(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imm_type   (imm_type),
        .base_instr (base_instr),
        .imm_in     (imm_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_last   (out_last),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic void model(
        input  logic [2:0]  t,
        input  logic [31:0] b,
        input  logic [63:0] i,
        output logic [31:0] w0,
        output logic [31:0] w1,
        output bit          two,
        output bit          err
    );
        longint s, h, lim31;
        bit ok;
        logic [31:0] v;
        logic [4:0] rd;
        s = i;
        lim31 = longint'(1) <<< 31;
        rd = b[11:7];
        two = 0;
        w0 = b;
        w1 = 32'd0;
        case (t)
            3'd0, 3'd1: ok = (s >= -2048 && s <= 2047);
            3'd2: ok = (s >= -4096 && s <= 4095 && s % 2 == 0);
            3'd3: ok = (s >= -lim31 && s < lim31 && s % 4096 == 0);
            3'd4: ok = (s >= -1048576 && s <= 1048575 && s % 2 == 0);
            3'd5: ok = (s >= -lim31 && s < lim31);
            default: ok = 0;
        endcase
        err = !ok;
        v = ok ? i[31:0] : 32'd0;
        case (t)
            3'd0: w0[31:20] = v[11:0];
            3'd1: begin
                w0[31:25] = v[11:5];
                w0[11:7] = v[4:0];
            end
            3'd2: begin
                w0[31] = v[12];
                w0[7] = v[11];
                w0[30:25] = v[10:5];
                w0[11:8] = v[4:1];
            end
            3'd3: w0[31:12] = v[31:12];
            3'd4: begin
                w0[31] = v[20];
                w0[30:21] = v[10:1];
                w0[20] = v[11];
                w0[19:12] = v[19:12];
            end
            3'd5: begin
                if (!ok) begin
                    w0[31:20] = 12'd0;
                end else if (s >= -2048 && s <= 2047) begin
                    w0 = {v[11:0], 5'd0, 3'd0, rd, 7'b0010011};
                end else begin
                    h = (s + 2048) >>> 12;
                    w0 = {h[19:0], rd, 7'b0110111};
                    w1 = {v[11:0], rd, 3'd0, rd, 7'b0011011};
                    two = 1;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [63:0] rand_imm();
        int m, r, k;
        int ks[4];
        logic [63:0] v;
        ks = '{11, 12, 20, 31};
        m = $urandom_range(0, 3);
        case (m)
            0: v = 64'($urandom_range(0, 16000)) - 64'd8000;
            1: begin
                r = $urandom();
                v = 64'(r);
                if ($urandom_range(0, 1) == 1) v[11:0] = 12'd0;
            end
            2: v = {$urandom(), $urandom()};
            default: begin
                k = ks[$urandom_range(0, 3)];
                v = 64'd1 << k;
                if ($urandom_range(0, 1) == 1) v = -v;
                v = v - 64'($urandom_range(0, 1));
            end
        endcase
        return v;
    endfunction

    // Called at a falling edge with the encoder idle.
    task automatic send(input logic [2:0] t, input logic [31:0] b,
                        input logic [63:0] i);
        in_valid = 1'b1;
        imm_type = t;
        base_instr = b;
        imm_in = i;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        imm_type = 3'd0;
        base_instr = 32'd0;
        imm_in = 64'd0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({out_valid, out_instr, out_last, out_err} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 0",
                     {out_valid, out_instr, out_last, out_err});
        end
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_itype();
        logic [63:0] redec;
        send(3'd0, 32'h00050513, 64'hFFFF_FFFF_FFFF_FFFF);
        n_chk++;
        if ({out_valid, out_instr, out_last, out_err} !==
            {1'b1, 32'hFFF50513, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL itype got %h_%b%b want FFF50513_10",
                     out_instr, out_last, out_err);
        end
        redec = {{52{out_instr[31]}}, out_instr[31:20]};
        n_chk++;
        if (redec !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL itype_redecode got %h want all ones", redec);
        end
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL itype_idle got %b want 0", out_valid);
        end
    endtask

    task automatic test_sb();
        send(3'd2, 32'h00000063, -64'sd4);
        n_chk++;
        if ({out_valid, out_instr, out_last, out_err} !==
            {1'b1, 32'hFE000EE3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sb_neg4 got %h_%b%b want FE000EE3_10",
                     out_instr, out_last, out_err);
        end
        @(negedge clk);
        send(3'd2, 32'h00000063, 64'd3);
        n_chk++;
        if ({out_valid, out_instr, out_last, out_err} !==
            {1'b1, 32'h00000063, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sb_misalign got %h_%b%b want 00000063_11",
                     out_instr, out_last, out_err);
        end
        @(negedge clk);
    endtask

    task automatic test_li();
        send(3'd5, 32'h00000500, 64'h12345FFF);
        n_chk++;
        if ({out_valid, out_instr, out_last, out_err} !==
            {1'b1, 32'h12346537, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL li_lui got %h_%b%b want 12346537_00",
                     out_instr, out_last, out_err);
        end
        @(negedge clk);
        n_chk++;
        if ({out_valid, out_instr, out_last, out_err} !==
            {1'b1, 32'hFFF5051B, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL li_addiw got %h_%b%b want FFF5051B_10",
                     out_instr, out_last, out_err);
        end
        @(negedge clk);
        send(3'd5, 32'h00000500, 64'h7FF);
        n_chk++;
        if ({out_valid, out_instr, out_last, out_err} !==
            {1'b1, 32'h7FF00513, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL li_small got %h_%b%b want 7FF00513_10",
                     out_instr, out_last, out_err);
        end
        @(negedge clk);
    endtask

    task automatic test_range();
        send(3'd0, 32'h00050513, 64'd2048);
        n_chk++;
        if ({out_valid, out_instr, out_last, out_err} !==
            {1'b1, 32'h00050513, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL i_2048 got %h_%b%b want 00050513_11",
                     out_instr, out_last, out_err);
        end
        @(negedge clk);
        send(3'd1, 32'h00A12023, -64'sd2048);
        n_chk++;
        if ({out_valid, out_instr, out_last, out_err} !==
            {1'b1, 32'h80A12023, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL s_neg2048 got %h_%b%b want 80A12023_10",
                     out_instr, out_last, out_err);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(3'd5, 32'h00000500, 64'h12345FFF);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if ({out_valid, out_instr, out_last, in_ready} !==
                {1'b1, 32'h12346537, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d got %h_%b%b want 12346537_00",
                         k, out_instr, out_last, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        imm_type = 3'd0;
        base_instr = 32'h00050513;
        imm_in = 64'd5;
        #1;
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_word1_ready got %b want 0", in_ready);
        end
        @(negedge clk);
        n_chk++;
        if ({out_valid, out_instr, out_last, out_err, in_ready} !==
            {1'b1, 32'hFFF5051B, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_word2 got %h_%b%b%b want FFF5051B_101",
                     out_instr, out_last, out_err, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++;
        if ({out_valid, out_instr, out_last, out_err} !==
            {1'b1, 32'h00550513, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_next got %h_%b%b want 00550513_10",
                     out_instr, out_last, out_err);
        end
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(3'd5, 32'h00000500, 64'h12345FFF);
        n_chk++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_word1 got %b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({out_valid, out_instr} !== 33'd0) begin
            n_fail++;
            $display("FAIL rm_async got %b_%h want 0_0", out_valid, out_instr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_in_ready got %b want 1", in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rm_no_addiw%0d got %b_%h want 0",
                         k, out_valid, out_instr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w0, w1;
        bit two, err;
        bit exp_rdy;
        q.delete();
        for (int c = 0; c < 1500; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            imm_type = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) imm_type = 3'd5;
            base_instr = $urandom();
            imm_in = rand_imm();
            #1;
            exp_rdy = (q.size() == 0) || (out_ready && q.size() == 1);
            n_chk++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rnd_in_ready c=%0d got %b want %b",
                         c, in_ready, exp_rdy);
            end
            n_chk++;
            if (q.size() == 0) begin
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_spurious c=%0d got %h want none",
                             c, out_instr);
                end
            end else if ({out_valid, out_instr, out_last, out_err} !==
                         {1'b1, q[0].w, q[0].last, q[0].err}) begin
                n_fail++;
                $display("FAIL rnd_word c=%0d got %b_%h_%b%b want 1_%h_%b%b",
                         c, out_valid, out_instr, out_last, out_err,
                         q[0].w, q[0].last, q[0].err);
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                model(imm_type, base_instr, imm_in, w0, w1, two, err);
                q.push_back('{w: w0, last: !two, err: err});
                if (two) q.push_back('{w: w1, last: 1'b1, err: 1'b0});
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6 && q.size() > 0; c++) begin
            #1;
            n_chk++;
            if ({out_valid, out_instr, out_last, out_err} !==
                {1'b1, q[0].w, q[0].last, q[0].err}) begin
                n_fail++;
                $display("FAIL drain_word got %b_%h_%b%b want 1_%h_%b%b",
                         out_valid, out_instr, out_last, out_err,
                         q[0].w, q[0].last, q[0].err);
            end
            void'(q.pop_front());
            @(negedge clk);
        end
        n_chk++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_left got %0d words valid=%b want 0",
                     q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_itype();
        test_sb();
        test_li();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
